uart_tx_engine: RTL and testbench
=================================

# uart_tx_engine

Serial transmitter that consumes the memory-mapped UART registers exported by the data memory (`io_uart_io_reg`, `io_uart_csr_reg`) and drives the board TX pin with 8N1 frames. Software writes the byte to the UART IO word and then toggles the CSR go bit. The block detects the request, buffers up to one pending byte, and reports busy, done and overrun status back toward the CSR read path.

## Interface
Parameters:
- `CLKS_PER_BIT`, 16'd868: default clocks per bit, used when the CSR divisor field is 0. Minimum effective value is 2.

Ports:
- `clk`  in  1  system clock, all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `io_uart_io_reg`  in  32  UART data word; bits [7:0] are the TX byte, [31:8] ignored
- `io_uart_csr_reg`  in  32  bit0 TX_GO (rising edge = send request), bit1 OVR_CLR (level, clears overrun), bits [31:16] baud divisor (0 = use `CLKS_PER_BIT`)
- `tx`  out  1  serial output, idle high
- `tx_busy`  out  1  high while a frame is in flight or a byte is pending
- `tx_done`  out  1  one-cycle pulse on the last cycle of each stop bit
- `tx_overrun`  out  1  sticky; set when a request arrives with the hold slot full

## Operation
- Request detect: `go_q` registers csr[0]. A request is `csr[0] & !go_q`. `go_q` resets to 1, so a go bit that is already high at reset release does not fire.
- Byte capture: data byte is sampled from `io_uart_io_reg[7:0]` on the same edge the request is detected.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE → START on a request. The byte is loaded into the shift register.
  - START → DATA after one bit time.
  - DATA → STOP after 8 bit times, sent LSB first.
  - STOP → IDLE or START after one bit time.
- Bit time: a baud counter counts 0..div-1. `div` is latched at each frame start as csr[31:16] if that field is nonzero, else `CLKS_PER_BIT`. A value of 1 is forced to 2. Changing the divisor mid-frame has no effect until the next frame.
- Hold slot (1 entry): a request while not IDLE stores the byte in the hold slot and sets `hold_valid`. A request while `hold_valid` is set drops the byte and sets `tx_overrun`.
- STOP completion cycle:
  - If `hold_valid` is set, the hold byte becomes the next frame (→ START) and `hold_valid` clears. A request on this same cycle is captured into the hold slot with no overrun.
  - Else, if a request arrives on this cycle, its byte goes directly to START.
  - Else → IDLE.
- `tx_overrun` clears while csr[1]=1. If set and clear happen on the same cycle, set wins.
- `tx_busy` = (state != IDLE) | `hold_valid`.
- Reset mid-frame: all state returns to reset values immediately. `tx` goes high asynchronously and the partial frame is abandoned.

## Timing
- Reset values: `tx`=1, `tx_busy`=0, `tx_done`=0, `tx_overrun`=0, state=IDLE, `hold_valid`=0, `go_q`=1, counters=0.
- All outputs are registered.
- Request detected at edge N: `tx` falls at edge N+1 and `tx_busy` rises at edge N+1.
- Each bit lasts exactly `div` cycles, so a frame is 10×div cycles from `tx` falling to the end of the stop bit.
- `tx_done` is high during the final cycle of the stop bit.
- Back-to-back frames: the next start bit begins on the cycle right after `tx_done`, with no idle gap.
- `tx_busy` falls on the cycle after the final `tx_done` when nothing is pending.

## Structure
- Package `uart_pkg`:
  - state enum `uart_tx_state_t`
  - CSR bit positions (`CSR_TX_GO`=0, `CSR_OVR_CLR`=1, `CSR_DIV_LSB`=16)
  - `UART_DEFAULT_DIV`
- Sub-module `uart_baud_counter`: loads the divisor, counts, and emits `bit_tick` on the last cycle of each bit. This is the natural split; the FSM, shifter and hold slot stay in the top.

## Test plan
(CLKS_PER_BIT=4 unless stated.)
- Single byte: data=0x55, rise csr[0] → `tx` sequence 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles. `tx_done` is high for 1 cycle 40 cycles after `tx` falls, and `tx_busy` drops on the next cycle.
- Divisor override: csr[31:16]=6, data=0xA3 → 60-cycle frame. Changing the divisor to 3 mid-frame leaves this frame at 60 cycles; the next frame is 30 cycles.
- Back-to-back: 0x01 sent, then 0x80 requested while busy → second start bit begins the cycle after the first `tx_done`, and `tx_overrun` stays 0.
- Overrun: three requests (0x11, 0x22, 0x33) within one frame → 0x11 and 0x22 are transmitted, 0x33 is dropped, and `tx_overrun`=1 until csr[1] is pulsed.
- Stop-cycle collision: a request on the `tx_done` cycle with the hold slot empty → that byte starts on the next cycle.
- Reset: csr[0]=1 held through reset → no frame after release. `rst_n` asserted mid-DATA → `tx`=1 and `tx_busy`=0 immediately.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit engine.
//   uart_tx_state_t  : transmit FSM state encoding
//   CSR_*            : bit positions inside the UART control/status word
//   UART_DEFAULT_DIV : clocks per bit when the CSR divisor field is zero
//   uart_eff_div()   : resolves the divisor actually used for a frame
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_tx_state_t;

    localparam int CSR_TX_GO   = 0;
    localparam int CSR_OVR_CLR = 1;
    localparam int CSR_DIV_LSB = 16;

    localparam logic [15:0] UART_DEFAULT_DIV = 16'd868;

    // A zero CSR field selects the default. Anything below 2 becomes 2,
    // so the bit counter always has at least two distinct counts.
    function automatic logic [15:0] uart_eff_div(input logic [15:0] csr_field,
                                                 input logic [15:0] dflt);
        logic [15:0] d;
        d = (csr_field != 16'd0) ? csr_field : dflt;
        if (d < 16'd2) begin
            d = 16'd2;
        end
        return d;
    endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-time counter for the UART transmitter.
// Ports:
//   clk, rst_n   : system clock, async active-low reset
//   load_i       : frame start; latch div_i and restart the count at 0
//   div_i [15:0] : clocks per bit for the frame being started (already >= 2)
//   run_i        : count while a frame is in flight
//   bit_tick_o   : high on the last clock of every bit
module uart_baud_counter
    import uart_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic [15:0] div_i,
    input  logic        run_i,
    output logic        bit_tick_o
);

    logic [15:0] cnt_q, cnt_d;
    logic [15:0] div_q, div_d;
    logic        last_cnt;

    assign last_cnt   = (cnt_q == (div_q - 16'd1));
    // Not gated by load_i: the stop-bit tick is what triggers a reload for
    // a back-to-back frame, so both are high on that cycle.
    assign bit_tick_o = run_i & last_cnt;

    always_comb begin
        cnt_d = cnt_q;
        div_d = div_q;
        if (load_i) begin
            div_d = div_i;
            cnt_d = 16'd0;
        end else if (run_i) begin
            cnt_d = last_cnt ? 16'd0 : (cnt_q + 16'd1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 16'd0;
            div_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/uart_tx_engine.sv
// 8N1 serial transmitter fed from the memory-mapped UART registers.
// Software writes the byte to the IO word, then raises the CSR go bit; each
// rising edge of go is one send request. One extra byte can wait in a hold
// slot while a frame is on the wire; a further request is dropped and flagged.
// Ports:
//   clk, rst_n            : system clock, async active-low reset
//   io_uart_io_reg [31:0] : [7:0] byte to send
//   io_uart_csr_reg[31:0] : [0] go, [1] overrun clear, [31:16] divisor (0 = default)
//   tx                    : serial line, idle high
//   tx_busy               : frame in flight or byte pending
//   tx_done               : one-cycle pulse in the last cycle of each stop bit
//   tx_overrun            : sticky, request lost because the hold slot was full
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_IDLE  | line idle, waiting for a request
// ST_START | driving the start bit (0)
// ST_DATA  | shifting out 8 data bits, LSB first
// ST_STOP  | driving the stop bit (1); may chain into START
//
// Every output is registered from the current state, so the line lags the
// FSM by exactly one clock; tx_done is aligned with that lagged stop bit.
module uart_tx_engine
    import uart_pkg::*;
#(
    parameter logic [15:0] CLKS_PER_BIT = UART_DEFAULT_DIV
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] io_uart_io_reg,
    input  logic [31:0] io_uart_csr_reg,
    output logic        tx,
    output logic        tx_busy,
    output logic        tx_done,
    output logic        tx_overrun
);

    uart_tx_state_t state_q, state_d;
    logic           go_q;
    logic [7:0]     shift_q, shift_d;
    logic [2:0]     bit_idx_q, bit_idx_d;
    logic [7:0]     hold_q, hold_d;
    logic           hold_valid_q, hold_valid_d;
    logic           ovr_q, ovr_d;
    logic           tx_q, tx_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic           req;
    logic           ovr_set;
    logic           start_frame;
    logic           stop_done;
    logic           bit_tick;
    logic [7:0]     req_byte;
    logic [15:0]    frame_div;
    logic           unused_bits;

    assign req       = io_uart_csr_reg[CSR_TX_GO] & ~go_q;
    assign req_byte  = io_uart_io_reg[7:0];
    assign frame_div = uart_eff_div(io_uart_csr_reg[31:CSR_DIV_LSB], CLKS_PER_BIT);
    assign stop_done = (state_q == ST_STOP) & bit_tick;

    assign unused_bits = ^{io_uart_io_reg[31:8], io_uart_csr_reg[CSR_DIV_LSB-1:2]};

    uart_baud_counter u_baud (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (start_frame),
        .div_i      (frame_div),
        .run_i      (state_q != ST_IDLE),
        .bit_tick_o (bit_tick)
    );

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_idx_d    = bit_idx_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        start_frame  = 1'b0;
        ovr_set      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d     = ST_START;
                    shift_d     = req_byte;
                    start_frame = 1'b1;
                end
            end
            ST_START: begin
                if (bit_tick) begin
                    state_d   = ST_DATA;
                    bit_idx_d = 3'd0;
                end
            end
            ST_DATA: begin
                if (bit_tick) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (bit_tick) begin
                    if (hold_valid_q) begin
                        state_d      = ST_START;
                        shift_d      = hold_q;
                        hold_valid_d = 1'b0;
                        start_frame  = 1'b1;
                        // The slot empties on this edge, so a simultaneous
                        // request refills it instead of overrunning.
                        if (req) begin
                            hold_d       = req_byte;
                            hold_valid_d = 1'b1;
                        end
                    end else if (req) begin
                        state_d     = ST_START;
                        shift_d     = req_byte;
                        start_frame = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (req && (state_q != ST_IDLE) && !stop_done) begin
            if (hold_valid_q) begin
                ovr_set = 1'b1;
            end else begin
                hold_d       = req_byte;
                hold_valid_d = 1'b1;
            end
        end
    end

    always_comb begin
        ovr_d = ovr_q;
        if (ovr_set) begin
            ovr_d = 1'b1;
        end else if (io_uart_csr_reg[CSR_OVR_CLR]) begin
            ovr_d = 1'b0;
        end

        tx_d = 1'b1;
        case (state_q)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_q[0];
            default:  tx_d = 1'b1;
        endcase

        busy_d = (state_q != ST_IDLE) | hold_valid_q;
        done_d = stop_done;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            go_q         <= 1'b1;
            shift_q      <= 8'd0;
            bit_idx_q    <= 3'd0;
            hold_q       <= 8'd0;
            hold_valid_q <= 1'b0;
            ovr_q        <= 1'b0;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            go_q         <= io_uart_csr_reg[CSR_TX_GO];
            shift_q      <= shift_d;
            bit_idx_q    <= bit_idx_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            ovr_q        <= ovr_d;
            tx_q         <= tx_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign tx         = tx_q;
    assign tx_busy    = busy_q;
    assign tx_done    = done_q;
    assign tx_overrun = ovr_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine. Stimulus pushes the frames it expects onto a
// queue; a line monitor decodes every frame on tx cycle by cycle and checks
// it against the head of the queue.
module tb_uart_tx_engine;

    localparam logic [15:0] CPB = 16'd4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] io_reg = 32'd0;
    logic [31:0] csr_reg = 32'd0;
    logic        tx, tx_busy, tx_done, tx_overrun;

    always #5 clk = ~clk;

    uart_tx_engine #(.CLKS_PER_BIT(CPB)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .io_uart_io_reg  (io_reg),
        .io_uart_csr_reg (csr_reg),
        .tx              (tx),
        .tx_busy         (tx_busy),
        .tx_done         (tx_done),
        .tx_overrun      (tx_overrun)
    );

    typedef struct packed {
        logic [7:0]  data;
        logic [15:0] div;
        logic        b2b;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // ---------------- line monitor ----------------
    longint cyc = 0;
    longint last_done = -100;
    bit     in_frame = 1'b0;
    exp_t   cur;
    int     k, slot, bit_errs, done_errs;
    logic   exp_bit;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            in_frame = 1'b0;
            exp_q.delete();
        end else begin
            if (!in_frame && tx == 1'b0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", 32'd1, 32'd0);
                    cur = '{data: 8'h00, div: CPB, b2b: 1'b0};
                end else begin
                    cur = exp_q.pop_front();
                    if (cur.b2b)
                        check($sformatf("b2b_gap_%02h", cur.data), 32'(cyc - last_done), 32'd1);
                end
                in_frame  = 1'b1;
                k         = 0;
                bit_errs  = 0;
                done_errs = 0;
            end
            if (in_frame) begin
                slot = k / int'(cur.div);
                if (slot == 0)      exp_bit = 1'b0;
                else if (slot == 9) exp_bit = 1'b1;
                else                exp_bit = cur.data[slot-1];
                if (tx !== exp_bit) bit_errs++;
                if (tx_done !== (k == 10 * int'(cur.div) - 1)) done_errs++;
                k++;
                if (k == 10 * int'(cur.div)) begin
                    check($sformatf("frame_%02h_bit_errors", cur.data), 32'(bit_errs), 32'd0);
                    check($sformatf("frame_%02h_done_errors", cur.data), 32'(done_errs), 32'd0);
                    in_frame = 1'b0;
                end
            end
            if (tx_done) last_done = cyc;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic expect_frame(input logic [7:0] b, input logic [15:0] d, input logic b2b);
        exp_q.push_back('{data: b, div: d, b2b: b2b});
    endtask

    // Called just after a rising edge; request is detected on the next edge.
    task automatic go(input logic [7:0] b);
        io_reg[7:0] = b;
        csr_reg[0]  = 1'b1;
        @(posedge clk); #1;
        csr_reg[0]  = 1'b0;
        @(posedge clk); #1;
    endtask

    // Returns one cycle after a tx_done pulse, or flags a timeout.
    task automatic wait_done(input string name);
        for (int i = 0; i < 2000 && !tx_done; i++) begin
            @(posedge clk); #1;
        end
        check({name, "_done_seen"}, 32'(tx_done), 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with go already high: no frame must follow release.
        rst_n   = 1'b0;
        csr_reg = 32'h0000_0001;
        repeat (3) @(posedge clk);
        #1;
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_busy", 32'(tx_busy), 32'd0);
        check("reset_done", 32'(tx_done), 32'd0);
        check("reset_overrun", 32'(tx_overrun), 32'd0);
        rst_n = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        check("go_high_at_reset_busy", 32'(tx_busy), 32'd0);
        check("go_high_at_reset_tx", 32'(tx), 32'd1);
        csr_reg[0] = 1'b0;
        @(posedge clk); #1;

        // Single byte 0x55 with request/latency checks.
        expect_frame(8'h55, CPB, 1'b0);
        io_reg[7:0] = 8'h55;
        csr_reg[0]  = 1'b1;
        @(posedge clk); #1;
        check("latency_tx_still_high", 32'(tx), 32'd1);
        check("latency_busy_still_low", 32'(tx_busy), 32'd0);
        csr_reg[0] = 1'b0;
        @(posedge clk); #1;
        check("latency_tx_low", 32'(tx), 32'd0);
        check("latency_busy_high", 32'(tx_busy), 32'd1);
        wait_done("single_55");
        check("single_busy_fall", 32'(tx_busy), 32'd0);

        // Divisor override, changed mid-frame.
        csr_reg[31:16] = 16'd6;
        expect_frame(8'hA3, 16'd6, 1'b0);
        go(8'hA3);
        repeat (20) @(posedge clk);
        #1;
        csr_reg[31:16] = 16'd3;
        wait_done("div6_a3");
        expect_frame(8'h3C, 16'd3, 1'b0);
        go(8'h3C);
        wait_done("div3_3c");
        csr_reg[31:16] = 16'd0;
        repeat (3) @(posedge clk);
        #1;

        // Back-to-back through the hold slot.
        expect_frame(8'h01, CPB, 1'b0);
        expect_frame(8'h80, CPB, 1'b1);
        go(8'h01);
        repeat (5) @(posedge clk);
        #1;
        go(8'h80);
        check("b2b_busy_pending", 32'(tx_busy), 32'd1);
        wait_done("b2b_01");
        wait_done("b2b_80");
        check("b2b_no_overrun", 32'(tx_overrun), 32'd0);
        repeat (3) @(posedge clk);
        #1;

        // Overrun: third request in one frame is dropped.
        expect_frame(8'h11, CPB, 1'b0);
        expect_frame(8'h22, CPB, 1'b1);
        go(8'h11);
        go(8'h22);
        check("ovr_not_yet", 32'(tx_overrun), 32'd0);
        go(8'h33);
        check("ovr_set", 32'(tx_overrun), 32'd1);
        wait_done("ovr_11");
        wait_done("ovr_22");
        repeat (10) @(posedge clk);
        #1;
        check("ovr_sticky", 32'(tx_overrun), 32'd1);
        check("ovr_idle_busy", 32'(tx_busy), 32'd0);
        csr_reg[1] = 1'b1;
        @(posedge clk); #1;
        csr_reg[1] = 1'b0;
        check("ovr_cleared", 32'(tx_overrun), 32'd0);

        // Request landing on the stop-completion edge with the slot empty.
        expect_frame(8'h5A, CPB, 1'b0);
        expect_frame(8'hC3, CPB, 1'b1);
        go(8'h5A);
        repeat (38) @(posedge clk);
        #1;
        io_reg[7:0] = 8'hC3;
        csr_reg[0]  = 1'b1;
        @(posedge clk); #1;
        check("collision_done_pulse", 32'(tx_done), 32'd1);
        csr_reg[0] = 1'b0;
        @(posedge clk); #1;
        check("collision_next_start", 32'(tx), 32'd0);
        wait_done("collision_c3");
        check("collision_no_overrun", 32'(tx_overrun), 32'd0);
        repeat (3) @(posedge clk);
        #1;

        // Reset asserted mid-DATA while the line is low.
        expect_frame(8'h00, CPB, 1'b0);
        go(8'h00);
        repeat (10) @(posedge clk);
        #2;
        check("pre_reset_tx_low", 32'(tx), 32'd0);
        rst_n = 1'b0;
        #1;
        check("midframe_reset_tx", 32'(tx), 32'd1);
        check("midframe_reset_busy", 32'(tx_busy), 32'd0);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("post_reset_busy", 32'(tx_busy), 32'd0);
        check("post_reset_tx", 32'(tx), 32'd1);

        // Recovery frame.
        expect_frame(8'h96, CPB, 1'b0);
        go(8'h96);
        wait_done("recover_96");

        repeat (10) @(posedge clk);
        #1;
        check("all_frames_seen", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
